// File: rtl/egress_tx_port.sv
// Egress transmitter: buffers switch-core words in a FIFO and frames them out as sop / vld words / eop.
// Optional statistics counters are built when EGRESS_STATS_EN is defined.
`timescale 1ns/1ps
module egress_tx_port #(
  parameter int DEPTH      = 1024,
  parameter int GAP_CYCLES = 2,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sw_vld,
  input  logic [15:0] sw_data,
  input  logic        sw_last,
  output logic        sw_ready,
  input  logic        tx_ready,
  output logic        rd_sop,
  output logic        rd_vld,
  output logic [15:0] rd_data,
  output logic        rd_eop,
  output logic        len_err,
  output logic        pkt_pending
`ifdef EGRESS_STATS_EN
  ,
  output logic [31:0] stat_pkts,
  output logic [15:0] stat_errs
`endif
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOP,
    ST_STREAM,
    ST_EOP,
    ST_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]   pkt_cnt_q, pkt_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [8:0]    hdr_len_q, hdr_len_d;
  logic [9:0]    word_cnt_q, word_cnt_d;
  logic          first_q, first_d;
  logic          err_q, err_d;
  logic          rd_vld_q, rd_vld_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          rd_eop_q, rd_eop_d;
  logic          len_err_q, len_err_d;
  logic          pkt_pending_q, pkt_pending_d;

  logic [16:0]   mem [DEPTH];
  logic [16:0]   rd_word;
  logic          full, empty, wr_en, pop, pop_last;
  logic [9:0]    word_cnt_inc;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign wr_en    = sw_vld && !full;
  assign rd_word  = mem[rd_ptr_q[AW-1:0]];
  assign pop      = (state_q == ST_STREAM) && tx_ready && !empty;
  assign pop_last = pop && rd_word[16];
  // Saturate so an oversized packet cannot wrap back onto a matching length.
  assign word_cnt_inc = (word_cnt_q == 10'h3ff) ? word_cnt_q : word_cnt_q + 10'd1;

  // NOTE: the storage array has no reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q[AW-1:0]] <= {sw_last, sw_data};
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    gap_cnt_d  = gap_cnt_q;
    hdr_len_d  = hdr_len_q;
    word_cnt_d = word_cnt_q;
    first_d    = first_q;
    err_d      = err_q;
    wr_ptr_d   = wr_en ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

    unique case ({wr_en && sw_last, pop_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + (AW+1)'(1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - (AW+1)'(1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase

    unique case (state_q)
      ST_IDLE: begin
        if (pkt_pending_q && tx_ready) state_d = ST_SOP;
      end
      ST_SOP: begin
        state_d    = ST_STREAM;
        first_d    = 1'b1;
        word_cnt_d = '0;
        err_d      = 1'b0;
      end
      ST_STREAM: begin
        if (pop) begin
          if (first_q) begin
            first_d   = 1'b0;
            hdr_len_d = rd_word[15:7];
            if (rd_word[16]) err_d = (rd_word[15:7] != 9'd0);
          end else begin
            word_cnt_d = word_cnt_inc;
            if (rd_word[16]) err_d = (word_cnt_inc != {1'b0, hdr_len_q});
          end
          if (rd_word[16]) state_d = ST_EOP;
        end
      end
      ST_EOP: begin
        state_d   = ST_GAP;
        gap_cnt_d = '0;
      end
      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else                                  gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    rd_vld_d      = pop;
    rd_data_d     = pop ? rd_word[15:0] : rd_data_q;
    rd_eop_d      = (state_q == ST_EOP);
    len_err_d     = (state_q == ST_EOP) && err_q;
    pkt_pending_d = (pkt_cnt_d != '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pkt_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      hdr_len_q     <= '0;
      word_cnt_q    <= '0;
      first_q       <= 1'b0;
      err_q         <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_data_q     <= '0;
      rd_eop_q      <= 1'b0;
      len_err_q     <= 1'b0;
      pkt_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      pkt_cnt_q     <= pkt_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      hdr_len_q     <= hdr_len_d;
      word_cnt_q    <= word_cnt_d;
      first_q       <= first_d;
      err_q         <= err_d;
      rd_vld_q      <= rd_vld_d;
      rd_data_q     <= rd_data_d;
      rd_eop_q      <= rd_eop_d;
      len_err_q     <= len_err_d;
      pkt_pending_q <= pkt_pending_d;
    end
  end

  assign sw_ready    = !full;
  assign rd_sop      = (state_q == ST_SOP);
  assign rd_vld      = rd_vld_q;
  assign rd_data     = rd_data_q;
  assign rd_eop      = rd_eop_q;
  assign len_err     = len_err_q;
  assign pkt_pending = pkt_pending_q;

`ifdef EGRESS_STATS_EN
  logic [31:0] stat_pkts_q, stat_pkts_d;
  logic [15:0] stat_errs_q, stat_errs_d;

  always_comb begin
    stat_pkts_d = stat_pkts_q;
    stat_errs_d = stat_errs_q;
    if (rd_eop_d  && (stat_pkts_q != '1)) stat_pkts_d = stat_pkts_q + 32'd1;
    if (len_err_d && (stat_errs_q != '1)) stat_errs_d = stat_errs_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts_q <= '0;
      stat_errs_q <= '0;
    end else begin
      stat_pkts_q <= stat_pkts_d;
      stat_errs_q <= stat_errs_d;
    end
  end

  assign stat_pkts = stat_pkts_q;
  assign stat_errs = stat_errs_q;
`endif

endmodule
